// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: cos(x), and sin(x) when CORDIC_SIN_EN is defined, for |x| <= 1 rad.
// One angle in flight; Q0.32 magnitude in, signed Q2.32 results out over a valid/ready handshake.
module cordic_rotator #(
  parameter int unsigned ITER = 32,
  parameter int unsigned W    = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [31:0]  in_mag,
  input  logic         in_special,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out
`ifdef CORDIC_SIN_EN
  ,
  output logic [W-1:0] sin_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] K_GAIN  = W'(64'h0_9B74_EDA8);
  localparam logic [W-1:0] ONE     = W'(64'h1_0000_0000);
  localparam logic [W-1:0] COS_ONE = W'(64'h0_8A51_407E);
`ifdef CORDIC_SIN_EN
  localparam logic [W-1:0] SIN_ONE = W'(64'h0_D76A_A478);
`endif

  // round(atan(2^-i) * 2^32); beyond i=10 the entry is exactly 2^(32-i)
  localparam logic [31:0] ATAN [32] = '{
    32'hC90F_DAA2, 32'h76B1_9C16, 32'h3EB6_EBF2, 32'h1FD5_BA9B,
    32'h0FFA_ADDC, 32'h07FF_556F, 32'h03FF_EAAB, 32'h01FF_FD55,
    32'h00FF_FFAB, 32'h007F_FFF5, 32'h003F_FFFF, 32'h0020_0000,
    32'h0010_0000, 32'h0008_0000, 32'h0004_0000, 32'h0002_0000,
    32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000,
    32'h0000_1000, 32'h0000_0800, 32'h0000_0400, 32'h0000_0200,
    32'h0000_0100, 32'h0000_0080, 32'h0000_0040, 32'h0000_0020,
    32'h0000_0010, 32'h0000_0008, 32'h0000_0004, 32'h0000_0002
  };

  state_t              state;
  logic [4:0]          cnt;
  logic signed [W-1:0] x, y, z;
  logic signed [W-1:0] xs, ys, at;
  logic signed [W-1:0] xn, yn, zn;
`ifdef CORDIC_SIN_EN
  logic                sign_q;
`endif

  always_comb begin
    xs = x >>> cnt;
    ys = y >>> cnt;
    at = signed'({{(W-32){1'b0}}, ATAN[cnt]});
    if (!z[W-1]) begin
      xn = x - ys;
      yn = y + xs;
      zn = z - at;
    end else begin
      xn = x + ys;
      yn = y - xs;
      zn = z + at;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      cos_out   <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
`ifdef CORDIC_SIN_EN
      sin_out   <= '0;
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is registered so it stays low for the first cycle after reset release
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            if (in_special) begin
              state     <= DONE;
              out_valid <= 1'b1;
              cos_out   <= (in_mag == 32'd0) ? ONE : COS_ONE;
`ifdef CORDIC_SIN_EN
              if (in_mag == 32'd0)
                sin_out <= '0;
              else
                sin_out <= in_sign ? -SIN_ONE : SIN_ONE;
`endif
            end else begin
              state <= RUN;
              x     <= K_GAIN;
              y     <= '0;
              z     <= signed'({{(W-32){1'b0}}, in_mag});
`ifdef CORDIC_SIN_EN
              sign_q <= in_sign;
`endif
            end
          end
        end
        RUN: begin
          x   <= xn;
          y   <= yn;
          z   <= zn;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cos_out   <= xn;
`ifdef CORDIC_SIN_EN
            sin_out   <= sign_q ? -yn : yn;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: real-arithmetic cos/sin reference, handshake,
// latency, backpressure and reset checks. Define CORDIC_SIN_EN to also check sin_out.
module tb_cordic_rotator;

  localparam int unsigned ITER = 32;
  localparam int unsigned W    = 34;
  localparam longint      TOL  = 16; // 2^-28 in Q2.32 LSBs

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sign = 1'b0;
  logic [31:0]  in_mag = '0;
  logic         in_special = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] cos_out;
`ifdef CORDIC_SIN_EN
  logic [W-1:0] sin_out;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cordic_rotator #(.ITER(ITER), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .in_special(in_special),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out)
`ifdef CORDIC_SIN_EN
    ,
    .sin_out   (sin_out)
`endif
  );

  task automatic check(input string tag, input longint got, input longint want, input longint tol);
    longint d;
    n_cmp++;
    d = got - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", tag, got, got, want, want, tol);
    end
  endtask

  function automatic real angle_of(input logic [31:0] mag, input bit spec);
    longint m;
    m = longint'({32'b0, mag});
    if (spec) return (mag == 32'd0) ? 0.0 : 1.0;
    return real'(m) / 4294967296.0;
  endfunction

  function automatic longint ref_cos(input logic [31:0] mag, input bit spec);
    return longint'($floor($cos(angle_of(mag, spec)) * 4294967296.0 + 0.5));
  endfunction

  function automatic longint ref_sin(input bit sgn, input logic [31:0] mag, input bit spec);
    longint v;
    v = longint'($floor($sin(angle_of(mag, spec)) * 4294967296.0 + 0.5));
    return sgn ? -v : v;
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic wait_ready();
    int unsigned k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_ready", longint'(in_ready), 1, 0);
  endtask

  // One request; hold = cycles of out_ready=0 after out_valid (0: out_ready high throughout).
  task automatic run_one(input bit sgn, input logic [31:0] mag, input bit spec, input int unsigned hold);
    longint      ec, tol;
    int unsigned k;
`ifdef CORDIC_SIN_EN
    longint      es;
    es = ref_sin(sgn, mag, spec);
`endif
    ec  = ref_cos(mag, spec);
    tol = spec ? 0 : TOL;
    out_ready = (hold == 0);
    wait_ready();
    in_valid   = 1'b1;
    in_sign    = sgn;
    in_mag     = mag;
    in_special = spec;
    @(negedge clk);
    in_valid = 1'b0;
    in_mag   = $urandom;
    in_sign  = 1'($urandom_range(0, 1));
    check("busy_ready", longint'(in_ready), 0, 0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    // out_valid is first sampled high by the consumer on edge k+1 after the accept edge
    check("latency", longint'(k + 1), spec ? 1 : longint'(ITER + 1), 0);
    check("cos", sx(cos_out), ec, tol);
`ifdef CORDIC_SIN_EN
    check("sin", sx(sin_out), es, tol);
`endif
    for (int unsigned h = 0; h < hold; h++) begin
      in_valid   = 1'b1;
      in_special = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", longint'(out_valid), 1, 0);
      check("bp_ready", longint'(in_ready), 0, 0);
      check("bp_cos", sx(cos_out), ec, tol);
`ifdef CORDIC_SIN_EN
      check("bp_sin", sx(sin_out), es, tol);
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drop_valid", longint'(out_valid), 0, 0);
    check("rel_ready", longint'(in_ready), 1, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seen;
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0, 0);
    check("rst_out_valid", longint'(out_valid), 0, 0);
    check("rst_cos", sx(cos_out), 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", longint'(in_ready), 1, 0);
    check("post_rst_valid", longint'(out_valid), 0, 0);
    check("post_rst_cos", sx(cos_out), 0, 0);

    run_one(1'b0, 32'h0000_0000, 1'b1, 0);   // +0
    run_one(1'b1, 32'h0000_0000, 1'b1, 0);   // -0
    run_one(1'b1, 32'h1234_5678, 1'b1, 0);   // -1.0, magnitude ignored
    run_one(1'b0, 32'h0000_0001, 1'b1, 3);   // +1.0
    run_one(1'b0, 32'h8000_0000, 1'b0, 10);  // 0.5 rad with backpressure
    run_one(1'b1, 32'h8000_0000, 1'b0, 0);
    run_one(1'b0, 32'hFFFF_FFFF, 1'b0, 0);
    run_one(1'b1, 32'h0000_0001, 1'b0, 1);

    // Release and a new request in the same cycle must not merge
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 32'd0; in_special = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("nm_valid", longint'(out_valid), 1, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("nm_idle_ready", longint'(in_ready), 1, 0);
    check("nm_idle_valid", longint'(out_valid), 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("nm_accept_ready", longint'(in_ready), 0, 0);
    check("nm_accept_valid", longint'(out_valid), 1, 0);
    check("nm_cos", sx(cos_out), 64'sh1_0000_0000, 0);
    @(negedge clk);
    check("nm_drop", longint'(out_valid), 0, 0);
    out_ready = 1'b0;

    // Reset in the middle of a run discards the result
    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 32'h3506_37BD; in_special = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0, 0);
    check("mid_rst_ready", longint'(in_ready), 0, 0);
    check("mid_rst_cos", sx(cos_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", longint'(seen), 0, 0);
    check("mid_rst_ready_after", longint'(in_ready), 1, 0);
    out_ready = 1'b0;
    run_one(1'b0, 32'h3506_37BD, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_one(1'($urandom_range(0, 1)), $urandom, (n % 8) == 7, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Iterative rotation-mode CORDIC engine that computes cos(x), and optionally sin(x), for an angle |x| ≤ 1 rad.
- Sits directly downstream of the float-to-fixed unpacker and consumes its outputs unchanged: sign, 32-bit Q0.32 magnitude, isSpecial.
- Results go to the fixed-to-float packer through a valid/ready handshake.
- One angle is in flight at a time; there is no pipelining across requests.

Parameters:
- ITER, 32, number of micro-rotations (legal 8..32).
- W, 34, internal and output datapath width: signed Q2.32 (2 integer bits incl. sign, 32 fraction bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  angle present.
- in_ready  output  1  engine can accept an angle.
- in_sign  input  1  angle sign (unpacker sign).
- in_mag  input  32  angle magnitude, unsigned Q0.32 (unpacker result).
- in_special  input  1  unpacker isSpecial: magnitude is exactly 0 or exactly 1.0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- cos_out  output  W  cos(x), signed Q2.32.
- sin_out  output  W  sin(x), signed Q2.32 (present only with CORDIC_SIN_EN).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0 while rst_n is low, 1 from the first clock after release.
  - out_valid=0; cos_out=0; sin_out=0; iteration counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid at a clock edge, capture the inputs.
    - If in_special=1, go to DONE.
    - Otherwise go to RUN.
  - RUN: one micro-rotation per cycle, counter i runs 0..ITER-1. After the i=ITER-1 cycle, go to DONE. in_ready=0.
  - DONE: out_valid=1 and outputs held stable. On out_ready=1, go to IDLE; out_valid drops the next cycle. in_ready=0.
- Special bypass: in_special=1 and in_mag==0 gives cos_out=0x1_0000_0000 (1.0) and sin=0.
- Special bypass: in_special=1 and in_mag≠0 means |x|=1.0 (in_mag is ignored). This gives cos_out=round(cos(1)·2^32)=0x0_8A51_407E and sin=round(sin(1)·2^32).
- Non-special capture:
  - x0 = K = round(0.6072529350·2^32) = 0x0_9B74_EDA8.
  - y0 = 0.
  - z0 = {2'b00, in_mag}.
  - Capture is unconditional on in_sign.
- Micro-rotation i:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y>>>i).
  - y ← y + d·(x>>>i).
  - z ← z − d·atan_i.
  - Shifts are arithmetic. All updates use the pre-cycle values.
- atan table: atan_i = round(atan(2^−i)·2^32), i=0..31, held as constant ROM, indexed by counter. atan_0 = 0xC90FDAA2.
- Result on entering DONE: cos_out = x, never negated (cos is even).
- Latency:
  - Non-special: accept edge to out_valid = ITER+1 cycles.
  - Special: 1 cycle.
  - Throughput is one result per ITER+2 cycles minimum.
- No overflow is possible: |x|,|y| ≤ 1.0 throughout. No saturation logic.
- in_valid while in_ready=0 is ignored and does not need to be held by the engine. The upstream stage holds in_valid until accepted.
- out_ready asserted before out_valid has no effect.
- A DONE→IDLE transition and a new in_valid in the same cycle are not merged. The new angle is accepted in the following IDLE cycle.
- rst_n asserted mid-RUN or mid-DONE: immediate return to the reset state; the in-flight result is discarded.
- Accuracy: |error| ≤ 2^−28 vs. ideal for ITER=32 over |x| ≤ 1.

Optional Feature:
- Macro: CORDIC_SIN_EN.
- Defined:
  - sin_out port exists.
  - sin_out = y, two's-complement negated when the captured in_sign=1 (sin is odd).
  - Special cases are also sign-applied: −1.0 gives −round(sin(1)·2^32), and −0 gives 0.
- Undefined:
  - sin_out port and the sign register are removed.
  - The y register remains (required by the x update).
  - cos behaviour and timing are identical.

Test Plan:
- Reset and idle: rst_n=0 then release, no in_valid → out_valid=0, cos_out=0, in_ready=1 from the first post-reset edge.
- Special zero: in_mag=0, in_special=1 → out_valid exactly 1 cycle after accept, cos_out=0x1_0000_0000, sin_out=0.
- Special −1.0: in_sign=1, in_special=1 → cos_out=0x0_8A51_407E, sin_out=−round(0.8414709848·2^32).
- Angle 0.5: in_mag=0x80000000 → out_valid after 33 cycles; cos_out within 2^−28 of 0.8775825619·2^32; sin_out within 2^−28 of 0.4794255386·2^32.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, a second in_valid is ignored; release → next cycle in_ready=1.
- Reset mid-run: assert rst_n=0 at iteration 15 of in_mag=0x350637BD → out_valid=0 immediately, no result is produced, and the next request completes normally.
